// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - byte enqueue handshake between the core logic and the UART transmitter
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       data_in;
  logic             data_valid;
  logic             ready;
  logic [CNT_W-1:0] fifo_count;

  modport master (
    output data_in,
    output data_valid,
    input  ready,
    input  fifo_count
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output ready,
    output fifo_count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 UART transmitter, LSB first, fed from a small circular byte FIFO
module uart_tx_fifo #(
  parameter int BAUD_RATE  = 115200,
  parameter int CLOCK_FREQ = 50000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus,
  output logic          tx_o,
  output logic          busy_o,
  output logic          tx_done_o
);
  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  // Never narrower than 17 bits so 100 MHz / 1200 baud still fits.
  localparam int BAUD_W = ($clog2(CLKS_PER_BIT) > 17) ? $clog2(CLKS_PER_BIT) : 17;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [BAUD_W-1:0] BIT_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BIT_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;

  logic              bit_end;
  logic              push;
  logic              pop;

  assign bit_end = (baud_q == BIT_LAST);
  // Full is judged on the pre-edge count, so a push while full is lost even if a pop frees a slot.
  assign push    = bus.data_valid && (count_q != FULL_CNT);
  // The head is consumed from IDLE, or at the last stop-bit cycle to chain frames with no gap.
  assign pop     = (count_q != '0) && ((state_q == IDLE) || (state_q == STOP && bit_end));

  assign bus.ready      = (count_q != FULL_CNT);
  assign bus.fifo_count = count_q;
  assign tx_o           = tx_q;
  assign busy_o         = busy_q;
  assign tx_done_o      = done_q;

  // Occupancy next state: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // FIFO pointers and count; pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // FIFO storage; stale entries are harmless because reset clears the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.data_in;
  end

  // Frame sequencer; tx, busy and tx_done are all flops so the off-chip line never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            baud_q  <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[bit_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        STOP: begin
          // Raised one cycle early so the registered pulse lands on the final stop cycle.
          if (baud_q == BIT_PRE) done_q <= 1'b1;
          if (bit_end) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= mem_q[rd_ptr_q];
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a frame-timeline model and line decoder
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx;
  logic busy;
  logic tx_done;

  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(
    .BAUD_RATE (100),
    .CLOCK_FREQ(1000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .tx_o     (tx),
    .busy_o   (busy),
    .tx_done_o(tx_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: queued bytes plus the frame in flight, located by its cycle offset 0..99.
  logic [7:0] mq [$];
  bit         m_active = 1'b0;
  int         m_off = 0;
  logic [7:0] m_cur = 8'h00;

  always @(posedge clk or posedge rst) begin
    bit         pv;
    logic [7:0] pd;
    if (rst) begin
      mq.delete();
      m_active = 1'b0;
      m_off = 0;
    end else begin
      pv = bus.data_valid && (mq.size() != DEPTH);
      pd = bus.data_in;
      if (m_active) begin
        if (m_off == 99) begin
          if (mq.size() != 0) begin
            m_cur = mq.pop_front();
            m_off = 0;
          end else begin
            m_active = 1'b0;
          end
        end else begin
          m_off++;
        end
      end else if (mq.size() != 0) begin
        m_cur = mq.pop_front();
        m_active = 1'b1;
        m_off = 0;
      end
      if (pv) mq.push_back(pd);
    end
  end

  // Every cycle: {tx, busy, tx_done, ready, fifo_count} against the model.
  always @(negedge clk) begin
    logic       etx;
    int         b;
    logic [6:0] exp_v;
    logic [6:0] act_v;
    if (!m_active) begin
      etx = 1'b1;
    end else begin
      b = m_off / 10;
      if (b == 0)      etx = 1'b0;
      else if (b <= 8) etx = m_cur[b-1];
      else             etx = 1'b1;
    end
    exp_v = {etx, m_active, (m_active && m_off == 99), (mq.size() != DEPTH), 3'(mq.size())};
    act_v = {tx, busy, tx_done, bus.ready, bus.fifo_count};
    check($sformatf("outputs_cyc%0d", cyc), 32'(act_v), 32'(exp_v));
  end

  // Line decoder: recovers bytes and start cycles, low-run lengths and tx_done pulses.
  logic [7:0] dec_q [$];
  int         dec_t [$];
  int         runs [$];
  int         done_cnt = 0;
  bit         in_fr = 1'b0;
  int         fs = 0;
  logic [7:0] sh = 8'h00;
  logic       prev_tx = 1'b1;
  int         run = 0;

  always @(negedge clk) begin
    int off;
    if (rst) begin
      in_fr = 1'b0;
      run = 0;
      prev_tx = 1'b1;
    end else begin
      if (tx_done === 1'b1) done_cnt++;
      if (tx === 1'b0) run++;
      else if (run != 0) begin
        runs.push_back(run);
        run = 0;
      end
      if (!in_fr) begin
        if (tx === 1'b0 && prev_tx === 1'b1) begin
          in_fr = 1'b1;
          fs = cyc;
        end
      end else begin
        off = cyc - fs;
        if (off >= 15 && off <= 85 && (off % 10) == 5) sh[(off-15)/10] = tx;
        if (off == 95) begin
          dec_q.push_back(sh);
          dec_t.push_back(fs);
          in_fr = 1'b0;
        end
      end
      prev_tx = tx;
    end
  end

  function automatic logic [31:0] dbyte(input int i);
    return (dec_q.size() > i) ? 32'(dec_q[i]) : 32'hdead;
  endfunction

  function automatic logic [31:0] dtime(input int i);
    return (dec_t.size() > i) ? 32'(dec_t[i]) : 32'hdead;
  endfunction

  function automatic logic [31:0] drun(input int i);
    return (runs.size() > i) ? 32'(runs[i]) : 32'hdead;
  endfunction

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic push1(input logic [7:0] d, output int n);
    bus.data_in = d;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #2;
    bus.data_valid = 1'b0;
    n = cyc;
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int t = 0;
    while (dec_q.size() < n && t < budget) begin
      @(posedge clk);
      t++;
    end
    #2;
    check(name, 32'(dec_q.size() >= n), 32'd1);
  endtask

  task automatic wait_cyc(input int target, input string name);
    int t = 0;
    while (cyc < target && t < 1000) begin
      @(posedge clk);
      #2;
      t++;
    end
    check(name, 32'(cyc), 32'(target));
  endtask

  task automatic clear_dec();
    dec_q.delete();
    dec_t.delete();
    runs.delete();
  endtask

  initial begin
    int n;
    int m;
    int s;
    int d0;
    logic [7:0] ov [5];
    logic [7:0] cc [5];
    bus.data_in = 8'h00;
    bus.data_valid = 1'b0;

    // Reset asserted before any clock edge must already force the idle state.
    #1 rst = 1'b1;
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_count", 32'(bus.fifo_count), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd1);
    idle(3);
    rst = 1'b0;
    idle(3);

    // Single byte 0x55.
    clear_dec();
    d0 = done_cnt;
    push1(8'h55, n);
    wait_frames(1, 150, "t1_timeout");
    idle(10);
    check("t1_byte", dbyte(0), 32'h55);
    check("t1_start_latency", dtime(0) - 32'(n), 32'd1);
    check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);

    // Back-to-back 0xA5, 0x3C on consecutive edges.
    clear_dec();
    bus.data_in = 8'hA5;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #2 bus.data_in = 8'h3C;
    @(posedge clk);
    #2 bus.data_valid = 1'b0;
    wait_frames(2, 300, "t2_timeout");
    idle(10);
    check("t2_byte0", dbyte(0), 32'hA5);
    check("t2_byte1", dbyte(1), 32'h3C);
    check("t2_spacing", dtime(1) - dtime(0), 32'd100);

    // Overflow: 0x01..0x05 pushed while 0xC7 is in flight; 0x05 must be dropped.
    clear_dec();
    push1(8'hC7, n);
    idle(3);
    bus.data_valid = 1'b1;
    for (int v = 1; v <= 5; v++) begin
      bus.data_in = 8'(v);
      @(posedge clk);
      #2;
    end
    bus.data_valid = 1'b0;
    check("t3_count_sat", 32'(bus.fifo_count), 32'd4);
    check("t3_ready_low", 32'(bus.ready), 32'd0);
    wait_frames(5, 600, "t3_timeout");
    idle(150);
    check("t3_frames", 32'(dec_q.size()), 32'd5);
    ov = '{8'hC7, 8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 5; i++) check($sformatf("t3_byte%0d", i), dbyte(i), 32'(ov[i]));

    // Boundary data 0x00 then 0xFF.
    clear_dec();
    bus.data_in = 8'h00;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #2 bus.data_in = 8'hFF;
    @(posedge clk);
    #2 bus.data_valid = 1'b0;
    wait_frames(2, 300, "t4_timeout");
    idle(20);
    check("t4_byte0", dbyte(0), 32'h00);
    check("t4_byte1", dbyte(1), 32'hFF);
    check("t4_low_run0", drun(0), 32'd90);
    check("t4_low_run1", drun(1), 32'd10);
    check("t4_runs", 32'(runs.size()), 32'd2);

    // Reset during data bit 3 of 0xC3 with two bytes queued.
    clear_dec();
    push1(8'hC3, n);
    idle(3);
    push1(8'h11, m);
    push1(8'h22, m);
    check("t5_count_queued", 32'(bus.fifo_count), 32'd2);
    s = n + 1;
    wait_cyc(s + 45, "t5_reach_bit3");
    check("t5_bit3_low", 32'(tx), 32'd0);
    rst = 1'b1;
    #1;
    check("t5_async_tx", 32'(tx), 32'd1);
    check("t5_async_count", 32'(bus.fifo_count), 32'd0);
    check("t5_async_busy", 32'(busy), 32'd0);
    idle(2);
    rst = 1'b0;
    idle(150);
    check("t5_silent", 32'(dec_q.size()), 32'd0);
    push1(8'h81, n);
    wait_frames(1, 150, "t5_timeout");
    idle(10);
    check("t5_byte", dbyte(0), 32'h81);

    // Push on the exact edge where STOP ends and the next byte is popped.
    clear_dec();
    push1(8'h10, n);
    idle(2);
    push1(8'h20, m);
    push1(8'h30, m);
    push1(8'h40, m);
    check("t6_count_pre", 32'(bus.fifo_count), 32'd3);
    s = n + 1;
    wait_cyc(s + 99, "t6_reach_stop_end");
    check("t6_done_now", 32'(tx_done), 32'd1);
    push1(8'h50, m);
    check("t6_count_post", 32'(bus.fifo_count), 32'd3);
    wait_frames(5, 700, "t6_timeout");
    idle(10);
    cc = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    for (int i = 0; i < 5; i++) check($sformatf("t6_byte%0d", i), dbyte(i), 32'(cc[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- UART transmitter, 8N1, LSB first, line idles high. Fed through a small internal FIFO so the core logic can queue several bytes without waiting on the serial line.
- Pairs with the FPGA's UART receive path on the same serial link, in the opposite direction: FPGA to Arduino.
- Typical use: returning ALU results over the GPIO TX pin.

Parameters:
- BAUD_RATE, 115200, serial bit rate in baud.
- CLOCK_FREQ, 50000000, clk frequency in Hz. CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE, integer division (434 at the defaults).
- FIFO_DEPTH, 4, number of byte entries. Must be a power of two, at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- data_in  in  8  byte to enqueue.
- data_valid  in  1  enqueue request. Sampled on the rising edge of clk.
- ready  out  1  FIFO not full. A push is accepted only when data_valid && ready.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte in flight.
- tx  out  1  serial output. Registered.
- busy  out  1  high whenever the FSM is not in IDLE.
- tx_done  out  1  one-cycle pulse in the last cycle of each stop bit.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values, applied immediately on rst assertion regardless of clk:
  - tx=1, busy=0, tx_done=0, fifo_count=0, ready=1.
  - FSM=IDLE, bit counter=0, baud counter=0, FIFO pointers=0.
- FIFO:
  - Circular buffer with read and write pointers that wrap modulo FIFO_DEPTH. Count is tracked separately.
  - Push on an edge with data_valid && ready: data is written and fifo_count increments at that edge.
  - ready = (fifo_count != FIFO_DEPTH).
  - Push while full is ignored: no data write, no pointer change. This still holds if a pop occurs on the same edge; ready is evaluated before the edge.
  - Push and pop on the same edge when not full: fifo_count is unchanged and both pointers advance.
- FSM states: IDLE, START, DATA, STOP. The baud counter counts 0..CLKS_PER_BIT-1; a bit ends when the counter is at CLKS_PER_BIT-1.
- IDLE:
  - tx=1.
  - If fifo_count != 0: pop the head into the shift register, clear the baud counter, go to START.
  - A byte pushed into an empty FIFO at edge N is popped at edge N+1, and tx falls after edge N+1.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shift[bit_index] for CLKS_PER_BIT cycles per bit.
  - After bit 7, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles. tx_done=1 in the final cycle.
  - At the end of STOP, if the FIFO is non-empty: pop and go directly to START, with no idle gap. Back-to-back frames are exactly 10*CLKS_PER_BIT cycles apart.
  - Otherwise go to IDLE.
- The byte in flight is held in the shift register and is unaffected by later pushes.
- tx changes only at bit boundaries. It must not glitch, since it drives an off-chip line directly from a flop.
- Reset mid-frame: the frame is aborted, tx returns high immediately, and the FIFO contents are discarded.
- Timing: the counter width must hold CLKS_PER_BIT-1 for CLOCK_FREQ up to 100 MHz at BAUD_RATE ≥ 1200 (17 bits minimum).

Test Plan:
- Bench parameters: CLOCK_FREQ=1000, BAUD_RATE=100, so CLKS_PER_BIT=10.
- Single byte: push 0x55 at edge N.
  - tx=0 for cycles N+2..N+11.
  - Then bits 1,0,1,0,1,0,1,0, each 10 cycles.
  - Stop bit high for 10 cycles, tx_done pulses once, busy returns to 0.
- Back-to-back: push 0xA5 then 0x3C on consecutive edges.
  - Frames are decoded as 0xA5 then 0x3C.
  - The start bit of frame 2 immediately follows the last stop cycle of frame 1, exactly 100 cycles after frame 1's start.
- Overflow, FIFO_DEPTH=4: while the first byte is in flight, push 0x01..0x05 on consecutive edges.
  - fifo_count saturates at 4, ready=0.
  - 0x05 is dropped.
  - Serial output is the in-flight byte, then 0x01, 0x02, 0x03, 0x04.
- Boundary data: push 0x00 then 0xFF.
  - Line is low for 90 cycles (start plus 8 data bits), then the stop bit.
  - Next frame: start bit low for 10 cycles, then high for 90 cycles.
- Reset mid-frame: assert rst during data bit 3 of 0xC3 with 2 bytes queued.
  - tx=1 and fifo_count=0 without waiting for a clk edge.
  - After release, no output until a new push; a new push of 0x81 transmits correctly.
- Simultaneous push/pop: with FIFO at 3 entries, push on the exact edge a STOP ends and a pop occurs.
  - fifo_count stays at 3 and no byte is lost.
